alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have, for each n in {0,1}, port reqn_valid  input  1  requester n has an operation.
REQ-005 The block SHALL have, for each n, port reqn_ready  output  1  operation accepted this cycle.
REQ-006 The block SHALL have, for each n, port reqn_op  input  3  operation code.
REQ-007 The block SHALL have, for each n, ports reqn_a and reqn_b  input  WIDTH  operands.
REQ-008 The block SHALL have, for each n, port respn_valid  output  1  result available to requester n.
REQ-009 The block SHALL have, for each n, port respn_ready  input  1  requester n takes the result.
REQ-010 The block SHALL have, for each n, port respn_data  output  WIDTH  result.
REQ-011 The block SHALL have, for each n, port respn_zero  output  1  result equals 0.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL share one combinational ALU between the two requesters and run one operation at a time.
REQ-014 The op codes SHALL be: 000 add, 001 sub (a-b), 010 and, 011 or, 100 xor, 101 slt signed, 110 sltu, 111 pass b; slt/sltu SHALL give 1 or 0 zero-extended; add/sub SHALL wrap modulo 2^WIDTH.
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-016 In IDLE the block SHALL grant exactly one valid requester; reqn_ready SHALL be combinational and high only for the granted requester in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both are valid, the requester not granted last wins; if only one is valid, it wins.
REQ-018 The last-grant pointer SHALL update only on an accepted handshake.
REQ-019 On acceptance (valid&ready at an edge), op and operands SHALL be registered, the grantee ID stored, and the state SHALL go to EXEC.
REQ-020 In EXEC the registered operands SHALL drive the ALU; at the next edge the result and zero flag SHALL be registered and the state SHALL go to RESP.
REQ-021 In RESP, respn_valid SHALL be high only for the stored ID; data SHALL be stable while valid and not ready.
REQ-022 When respn_valid&respn_ready is seen at an edge, the state SHALL return to IDLE.
REQ-023 Latency SHALL be exactly 2 cycles from the accept edge to respn_valid high; peak throughput SHALL be one operation per 3 cycles.
REQ-024 respn_data and respn_zero for the non-selected requester SHALL read 0.
REQ-025 Changes to reqn_* while not ready SHALL have no effect; a request withdrawn before acceptance SHALL be dropped silently.
REQ-026 respn_ready asserted outside RESP, or for the non-owning requester, SHALL be ignored.

Reset
REQ-027 Assertion of rst_n low SHALL immediately force IDLE, all ready/valid outputs 0, data 0, zero 0, busy 0, and a pointer value making requester 0 win the first tie.
REQ-028 Reset mid-operation SHALL discard the in-flight operation with no response issued.

Structure
REQ-029 The op-code constants and WIDTH default SHALL live in a shared package, alu_pkg.
REQ-030 The combinational ALU SHALL be a separate sub-module, alu32, containing the per-bit logic; alu_arb SHALL contain only the arbiter, FSM and registers.

Verification
REQ-031 Single request: req0 add 0x0000_0005+0x0000_0003 -> req0_ready same cycle; resp0_valid 2 cycles after accept, data 0x0000_0008, zero 0.
REQ-032 Tie: both valid from reset with resp_ready=1 held -> grants ordered req0, req1, req0, req1; each resp routed only to the owning port.
REQ-033 Backpressure: xor 0xFFFF_0000^0xFFFF_0000 with resp1_ready low for 5 cycles -> resp1_valid held, data 0, zero 1, busy 1, req0_ready 0 throughout.
REQ-034 Arithmetic edges: add 0xFFFF_FFFF+1 -> 0 and zero 1; slt 0x8000_0000 vs 1 -> 1; sltu same operands -> 0; sub 0-1 -> 0xFFFF_FFFF.
REQ-035 Reset in EXEC: rst_n low one cycle -> all outputs 0 at once; no response afterward; the next tie grants req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width default, op codes, arbiter FSM states.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SLTU = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu32.sv
// Purely combinational ALU shared by both requesters of alu_arb.
module alu32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  logic [WIDTH-1:0] and_v, or_v, xor_v;
  logic [WIDTH-1:0] sum_v, dif_v;
  logic             lt_s, lt_u;

  // bitwise logic built one bit cell at a time
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_v[i] = a[i] & b[i];
    assign or_v[i]  = a[i] | b[i];
    assign xor_v[i] = a[i] ^ b[i];
  end

  // add/sub wrap naturally at WIDTH bits
  assign sum_v = a + b;
  assign dif_v = a - b;
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // result select by op code; comparisons are zero-extended
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = sum_v;
      OP_SUB:  y = dif_v;
      OP_AND:  y = and_v;
      OP_OR:   y = or_v;
      OP_XOR:  y = xor_v;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
      default: y = b;
    endcase
  end

  assign zero = ~|y;

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for one shared ALU.
// One operation in flight: IDLE (grant/accept) -> EXEC (compute) -> RESP (hold result).
module alu_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp0_zero,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             resp1_zero,
  output logic             busy
);

  arb_state_e       state_q, state_d;
  logic             last_q;      // id granted most recently; reset to 1 so req0 wins first tie
  logic             id_q;        // owner of the in-flight operation
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  logic             gnt_any, gnt_id;
  logic             accept, resp_hs;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  alu32 #(.WIDTH(WIDTH)) u_alu (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  assign accept  = (state_q == S_IDLE) && gnt_any;
  assign resp_hs = (state_q == S_RESP) && (id_q ? resp1_ready : resp0_ready);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)  state_d = S_EXEC;
      S_EXEC:               state_d = S_RESP;
      S_RESP:  if (resp_hs) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // capture request on accept, capture ALU result at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      id_q   <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        op_q   <= gnt_id ? req1_op : req0_op;
        a_q    <= gnt_id ? req1_a  : req0_a;
        b_q    <= gnt_id ? req1_b  : req0_b;
      end
      if (state_q == S_EXEC) begin
        res_q  <= alu_y;
        zero_q <= alu_zero;
      end
    end
  end

  // outputs: ready only in IDLE for the grantee, response only to the owner
  always_comb begin
    req0_ready  = accept && !gnt_id;
    req1_ready  = accept &&  gnt_id;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_data  = '0;
    resp1_data  = '0;
    resp0_zero  = 1'b0;
    resp1_zero  = 1'b0;
    busy        = (state_q != S_IDLE);
    if (state_q == S_RESP) begin
      if (id_q) begin
        resp1_valid = 1'b1;
        resp1_data  = res_q;
        resp1_zero  = zero_q;
      end else begin
        resp0_valid = 1'b1;
        resp0_data  = res_q;
        resp0_zero  = zero_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: single ops, round-robin ties, backpressure, reset mid-op.
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_zero, resp1_zero, busy;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  alu_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_data(resp0_data), .resp0_zero(resp0_zero),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_data(resp1_data), .resp1_zero(resp1_zero),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " r0rdy"}, req0_ready, 0);
    chk({tag, " r1rdy"}, req1_ready, 0);
    chk({tag, " v0"}, resp0_valid, 0);
    chk({tag, " v1"}, resp1_valid, 0);
    chk({tag, " d0"}, resp0_data, 0);
    chk({tag, " d1"}, resp1_data, 0);
    chk({tag, " z0"}, resp0_zero, 0);
    chk({tag, " z1"}, resp1_zero, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // one isolated op on requester n with both resp_ready held high
  task automatic single(input string tag, input int n, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_z);
    set_req(n, 1'b1, op, a, b);
    #1;
    chk({tag, " rdy"}, (n == 0) ? req0_ready : req1_ready, 1);
    chk({tag, " other rdy"}, (n == 0) ? req1_ready : req0_ready, 0);
    step();
    set_req(n, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk({tag, " exec busy"}, busy, 1);
    chk({tag, " exec vld"}, (n == 0) ? resp0_valid : resp1_valid, 0);
    step();
    chk({tag, " vld"}, (n == 0) ? resp0_valid : resp1_valid, 1);
    chk({tag, " data"}, (n == 0) ? resp0_data : resp1_data, exp_d);
    chk({tag, " zero"}, (n == 0) ? resp0_zero : resp1_zero, exp_z);
    chk({tag, " other vld"}, (n == 0) ? resp1_valid : resp0_valid, 0);
    chk({tag, " other data"}, (n == 0) ? resp1_data : resp0_data, 0);
    step();
    chk({tag, " back idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #1;
    chk_idle_outs("reset");
    step();
    step();
    rst_n = 1'b1;
    #1;

    // basic add, then arithmetic/logic edges
    single("add5+3",   0, 3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
    single("addwrap",  1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    single("slt",      0, 3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
    single("sltu",     1, 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
    single("sub0-1",   0, 3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    single("and",      1, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    single("or",       0, 3'b011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);
    single("passb",    1, 3'b111, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0);

    // tie from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b000, 32'd10, 32'd10);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie%0d r0rdy", k), req0_ready, (k % 2 == 0));
      chk($sformatf("tie%0d r1rdy", k), req1_ready, (k % 2 == 1));
      step();
      step();
      chk($sformatf("tie%0d v0", k), resp0_valid, (k % 2 == 0));
      chk($sformatf("tie%0d v1", k), resp1_valid, (k % 2 == 1));
      chk($sformatf("tie%0d d0", k), resp0_data, (k % 2 == 0) ? 32'd2 : 32'd0);
      chk($sformatf("tie%0d d1", k), resp1_data, (k % 2 == 1) ? 32'd20 : 32'd0);
      step();
    end
    set_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;

    // backpressure on req1 while req0 waits and resp0_ready is high
    resp1_ready = 1'b0;
    set_req(1, 1'b1, 3'b100, 32'hFFFF_0000, 32'hFFFF_0000);
    #1;
    chk("bp r1rdy", req1_ready, 1);
    step();
    set_req(1, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd2);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d v1", k), resp1_valid, 1);
      chk($sformatf("bp%0d d1", k), resp1_data, 0);
      chk($sformatf("bp%0d z1", k), resp1_zero, 1);
      chk($sformatf("bp%0d busy", k), busy, 1);
      chk($sformatf("bp%0d r0rdy", k), req0_ready, 0);
      chk($sformatf("bp%0d v0", k), resp0_valid, 0);
      step();
    end
    resp1_ready = 1'b1;
    #1;
    chk("bp release v1", resp1_valid, 1);
    step();
    chk("bp next r0rdy", req0_ready, 1);
    step();
    set_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    chk("bp req0 v0", resp0_valid, 1);
    chk("bp req0 d0", resp0_data, 32'd3);
    step();

    // reset while in EXEC
    set_req(0, 1'b1, 3'b000, 32'd7, 32'd7);
    #1;
    chk("rst r0rdy", req0_ready, 1);
    step();
    set_req(0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("rst exec busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rstexec");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postrst%0d v0", k), resp0_valid, 0);
      chk($sformatf("postrst%0d busy", k), busy, 0);
    end
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b000, 32'd1, 32'd1);
    #1;
    chk("postrst tie r0rdy", req0_ready, 1);
    chk("postrst tie r1rdy", req1_ready, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
